// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM controller: command encodings, FSM states
// and default memory geometry.
package spi_ram_pkg;

    localparam int DEFAULT_MEM_DEPTH = 256;
    localparam int DEFAULT_ADDR_SIZE = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    // Prefixed names keep the TX_HOLD state distinct from the TX_HOLD parameter.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_ISSUE,
        ST_TX_HOLD
    } state_t;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port 8-bit RAM: synchronous write, registered synchronous read,
// one access per cycle. Contents are never reset.
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] rdata_q;

    // Read data only changes on a read access, so it holds between reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI RAM controller: decodes received SPI words into address/data/read
// commands and paces read data towards the serializer.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int TX_HOLD   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       rd_err,
    output logic       ovf_err
);

    localparam int HOLD_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    function automatic logic [ADDR_SIZE-1:0] wrap_addr(input logic [7:0] payload);
        return ADDR_SIZE'(32'(payload) % 32'(MEM_DEPTH));
    endfunction

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    cmd_t                 cmd;
    logic [7:0]           payload;

    state_t               state_q,     state_d;
    logic [HOLD_W-1:0]    hold_cnt_q,  hold_cnt_d;
    logic [ADDR_SIZE-1:0] wr_addr_q,   wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q,   rd_addr_d;
    logic                 rd_armed_q,  rd_armed_d;
    logic                 req_valid_q, req_valid_d;
    logic                 req_we_q,    req_we_d;
    logic [ADDR_SIZE-1:0] req_addr_q,  req_addr_d;
    logic [7:0]           req_data_q,  req_data_d;
    logic                 load_q,      load_d;
    logic [7:0]           dout_q,      dout_d;
    logic                 tx_valid_q,  tx_valid_d;
    logic                 rd_err_q,    rd_err_d;
    logic                 ovf_err_q,   ovf_err_d;
    logic [7:0]           arr_rdata;

    assign cmd     = cmd_t'(din[9:8]);
    assign payload = din[7:0];

    // Every array access is registered one cycle after decode, and only one word
    // is decoded per cycle, so writes and reads never collide on the single port.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        rd_armed_d  = rd_armed_q;
        req_valid_d = 1'b0;
        req_we_d    = 1'b0;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        rd_err_d    = 1'b0;
        ovf_err_d   = 1'b0;
        load_d      = (state_q == ST_READ_ISSUE);
        tx_valid_d  = load_q;
        dout_d      = load_q ? arr_rdata : dout_q;

        case (state_q)
            ST_READ_ISSUE: begin
                state_d    = ST_TX_HOLD;
                hold_cnt_d = '0;
            end
            ST_TX_HOLD: begin
                if (hold_cnt_q == HOLD_W'(TX_HOLD - 1)) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: ;
        endcase

        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = wrap_addr(payload);
                CMD_WR_DATA: begin
                    req_valid_d = 1'b1;
                    req_we_d    = 1'b1;
                    req_addr_d  = wr_addr_q;
                    req_data_d  = payload;
                    wr_addr_d   = next_addr(wr_addr_q);
                end
                CMD_RD_ADDR: begin
                    rd_addr_d  = wrap_addr(payload);
                    rd_armed_d = 1'b1;
                end
                CMD_RD_DATA: begin
                    rd_err_d  = !rd_armed_q;
                    ovf_err_d = (state_q != ST_IDLE);
                    if (rd_armed_q && state_q == ST_IDLE) begin
                        req_valid_d = 1'b1;
                        req_we_d    = 1'b0;
                        req_addr_d  = rd_addr_q;
                        rd_addr_d   = next_addr(rd_addr_q);
                        state_d     = ST_READ_ISSUE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clearing load_q on reset is what aborts an in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rd_armed_q  <= 1'b0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            load_q      <= 1'b0;
            dout_q      <= '0;
            tx_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_armed_q  <= rd_armed_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            load_q      <= load_d;
            dout_q      <= dout_d;
            tx_valid_q  <= tx_valid_d;
            rd_err_q    <= rd_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    spi_ram_array #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_array (
        .clk  (clk),
        .en   (req_valid_q),
        .we   (req_we_q),
        .addr (req_addr_q),
        .wdata(req_data_q),
        .rdata(arr_rdata)
    );

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign rd_err   = rd_err_q;
    assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: directed SPI words push expected output
// events; a negedge monitor matches every DUT pulse against them.
module tb_spi_ram_ctrl;

    localparam int K_TX  = 0;
    localparam int K_RD  = 1;
    localparam int K_OVF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = 10'h3FF;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       rd_err;
    logic       ovf_err;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    spi_ram_ctrl #(
        .MEM_DEPTH(256),
        .ADDR_SIZE(8),
        .TX_HOLD  (9)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .rx_valid(rx_valid),
        .dout    (dout),
        .tx_valid(tx_valid),
        .rd_err  (rd_err),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected event for a word issued now; offset is measured from the current cycle.
    task automatic expectEvent(input int kind, input logic [7:0] data, input int offset);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = cyc + offset;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] payload);
        din      = {cmd, payload};
        rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        din      = 10'h3FF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic matchEvent(input int kind, input logic [7:0] data);
        int idx;
        string nm;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].kind == kind) idx = i;
        end
        nm = (kind == K_TX) ? "tx" : (kind == K_RD) ? "rd_err" : "ovf_err";
        if (idx < 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_%s: got pulse at cycle %0d, expected none (dout=0x%0h)", nm, cyc, dout);
        end else begin
            checkOutput({nm, "_data"}, int'(data), int'(sb[idx].data));
            checkOutput({nm, "_cycle"}, cyc, sb[idx].cyc);
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid === 1'b1) matchEvent(K_TX, dout);
            if (rd_err === 1'b1) matchEvent(K_RD, 8'h00);
            if (ovf_err === 1'b1) matchEvent(K_OVF, 8'h00);
        end
    end

    initial begin
        $display("[TB] start");
        idle(3);
        rst = 1'b0;

        checkOutput("reset_dout", int'(dout), 0);
        checkOutput("reset_tx_valid", int'(tx_valid), 0);
        checkOutput("reset_rd_err", int'(rd_err), 0);
        checkOutput("reset_ovf_err", int'(ovf_err), 0);

        // Unarmed read straight after reset
        expectEvent(K_RD, 8'h00, 1);
        applyStimulus(2'b11, 8'h00);
        idle(6);
        checkOutput("unarmed_dout", int'(dout), 0);

        // Write then read back
        applyStimulus(2'b00, 8'h10);
        applyStimulus(2'b01, 8'hA5);
        applyStimulus(2'b10, 8'h10);
        expectEvent(K_TX, 8'hA5, 3);
        applyStimulus(2'b11, 8'h00);
        idle(12);

        // Auto-increment with wrap at the top of memory
        applyStimulus(2'b00, 8'hFF);
        applyStimulus(2'b01, 8'h11);
        applyStimulus(2'b01, 8'h22);
        applyStimulus(2'b10, 8'hFF);
        expectEvent(K_TX, 8'h11, 3);
        applyStimulus(2'b11, 8'h00);
        idle(12);
        expectEvent(K_TX, 8'h22, 3);
        applyStimulus(2'b11, 8'h00);
        idle(12);
        checkOutput("hold_dout", int'(dout), 'h22);

        // Overlapping reads during the hold window
        applyStimulus(2'b00, 8'h20);
        applyStimulus(2'b01, 8'hC1);
        applyStimulus(2'b01, 8'hC2);
        applyStimulus(2'b01, 8'hC3);
        applyStimulus(2'b10, 8'h20);
        expectEvent(K_TX, 8'hC1, 3);
        applyStimulus(2'b11, 8'h00);
        idle(2);
        expectEvent(K_OVF, 8'h00, 1);
        applyStimulus(2'b11, 8'h00);
        idle(8);
        expectEvent(K_TX, 8'hC2, 3);
        applyStimulus(2'b11, 8'h00);
        idle(12);
        expectEvent(K_TX, 8'hC3, 3);
        applyStimulus(2'b11, 8'h00);
        idle(12);

        // A write landing while the read is being issued
        applyStimulus(2'b00, 8'h40);
        applyStimulus(2'b01, 8'h77);
        applyStimulus(2'b10, 8'h40);
        expectEvent(K_TX, 8'h77, 3);
        applyStimulus(2'b11, 8'h00);
        applyStimulus(2'b01, 8'h88);
        idle(12);
        expectEvent(K_TX, 8'h88, 3);
        applyStimulus(2'b11, 8'h00);
        idle(12);

        // Reset in the cycle after an accepted read
        applyStimulus(2'b00, 8'h50);
        applyStimulus(2'b01, 8'h3C);
        applyStimulus(2'b10, 8'h50);
        applyStimulus(2'b11, 8'h00);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(6);
        checkOutput("abort_dout", int'(dout), 0);
        checkOutput("abort_tx_valid", int'(tx_valid), 0);
        expectEvent(K_RD, 8'h00, 1);
        applyStimulus(2'b11, 8'h00);
        idle(3);
        applyStimulus(2'b10, 8'h50);
        expectEvent(K_TX, 8'h3C, 3);
        applyStimulus(2'b11, 8'h00);
        idle(12);
        applyStimulus(2'b10, 8'h10);
        expectEvent(K_TX, 8'hA5, 3);
        applyStimulus(2'b11, 8'h00);
        idle(15);

        while (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_event: kind %0d data 0x%0h expected at cycle %0d, got nothing",
                     sb[0].kind, sb[0].data, sb[0].cyc);
            sb.delete(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 256, SHALL set the number of 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8, SHALL set the address width; MEM_DEPTH <= 2**ADDR_SIZE.
REQ-003 Parameter TX_HOLD, default 9, SHALL set the number of cycles after a tx_valid pulse during which the downstream serializer is busy.
REQ-004 clk  in  1  SHALL be the single clock; all logic is on the rising edge.
REQ-005 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 din  in  10  SHALL carry the received SPI word: [9:8] is the command and [7:0] is the payload.
REQ-007 rx_valid  in  1  SHALL qualify din for exactly one cycle per received word.
REQ-008 dout  out  8  SHALL carry read data to the serializer's parallel input.
REQ-009 tx_valid  out  1  SHALL be a one-cycle pulse qualifying dout; it is the serializer's load strobe.
REQ-010 rd_err  out  1  SHALL pulse for one cycle on a read-data command issued before any read-address command.
REQ-011 ovf_err  out  1  SHALL pulse for one cycle on a read-data command dropped during the hold window.

Function
REQ-012 Commands SHALL be decoded only when rx_valid=1; when rx_valid=0, no state, address or memory change SHALL occur.
REQ-013 Command 00 SHALL load wr_addr <= din[7:0].
REQ-014 Command 01 SHALL write mem[wr_addr] <= din[7:0] and then set wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 -> 0.
REQ-015 Command 10 SHALL load rd_addr <= din[7:0] and set rd_armed <= 1; rd_armed SHALL stay set until reset.
REQ-016 Command 11 with rd_armed=1 in state IDLE SHALL read mem[rd_addr] and then set rd_addr <= rd_addr+1, wrapping MEM_DEPTH-1 -> 0.
REQ-017 Read latency SHALL be exactly 2 cycles: rx_valid sampled at edge N, array read at edge N+1, dout valid and tx_valid=1 after edge N+2.
REQ-018 The FSM SHALL have exactly three states: IDLE, READ_ISSUE and TX_HOLD.
REQ-019 IDLE SHALL go to READ_ISSUE on an accepted command 11.
REQ-020 READ_ISSUE SHALL go to TX_HOLD, asserting tx_valid for 1 cycle.
REQ-021 TX_HOLD SHALL count TX_HOLD cycles and then return to IDLE.
REQ-022 In READ_ISSUE or TX_HOLD, a command 11 SHALL be dropped: ovf_err pulses, and rd_addr and dout are unchanged.
REQ-023 Commands 00, 01 and 10 SHALL be accepted in every state.
REQ-024 Command 11 with rd_armed=0 SHALL pulse rd_err, SHALL NOT change the FSM state and SHALL NOT change rd_addr; if it arrives outside IDLE, ovf_err SHALL pulse as well.
REQ-025 dout SHALL hold its last value between reads.
REQ-026 A write followed by a read of the same address on the next rx_valid SHALL return the newly written data.
REQ-027 Payload addresses >= MEM_DEPTH SHALL be reduced modulo MEM_DEPTH.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL force: dout=0, tx_valid=0, rd_err=0, ovf_err=0, wr_addr=0, rd_addr=0, rd_armed=0, state=IDLE, hold counter=0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 A reset asserted during READ_ISSUE or TX_HOLD SHALL abort the read; no tx_valid SHALL follow the reset.

Structure
REQ-031 Package spi_ram_pkg SHALL hold the command encodings (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11), the state enum and the default MEM_DEPTH and ADDR_SIZE.
REQ-032 Sub-module spi_ram_array SHALL implement the single-port memory: synchronous write, registered synchronous read, one access per cycle.
REQ-033 spi_ram_ctrl SHALL contain the decode logic, the address registers, the FSM and the hold counter.

Verification
REQ-034 Write-then-read: cmd 00/0x10, 01/0xA5, 10/0x10, 11/xx -> tx_valid exactly 2 cycles after the last rx_valid, with dout=0xA5.
REQ-035 Auto-increment and wrap: cmd 00/0xFF, then 01/0x11 and 01/0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22; a read stream from 0xFF returns 0x11 then 0x22.
REQ-036 Unarmed read: cmd 11 immediately after reset -> rd_err pulses once, tx_valid stays 0, state stays IDLE.
REQ-037 Hold overlap: two cmd-11 words 3 cycles apart -> one tx_valid, ovf_err pulses once, rd_addr advances by 1; a third cmd 11 at TX_HOLD+2 cycles after the first tx_valid -> a second tx_valid with the next word.
REQ-038 Reset mid-read: rst=1 in the cycle after a cmd-11 rx_valid -> no tx_valid, dout=0, and memory contents persist (a rearm and read returns the prior data).
